// File: rtl/bus_pkg.sv
// bus_pkg: shared constants, state encoding and helpers for the word-path arbiter
package bus_pkg;
    localparam int NUM_REQ = 4;
    localparam logic [0:1] REQ_FETCH = 2'd0;
    localparam logic [0:1] REQ_LDST  = 2'd1;
    localparam logic [0:1] REQ_DMA   = 2'd2;
    localparam logic [0:1] REQ_DBG   = 2'd3;
    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;
    function automatic logic [0:NUM_REQ-1] onehot4(input logic [0:1] idx);
        return 4'b1000 >> idx;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational rotate-priority picker, first set request scanning from i_ptr
module rr_pick
    import bus_pkg::*;
(
    input  logic [0:NUM_REQ-1] i_req,
    input  logic [0:1]         i_ptr,
    output logic               o_valid,
    output logic [0:1]         o_idx
);
    always_comb begin
        o_valid = |i_req;
        o_idx = i_ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (i_req[i_ptr + 2'(k)]) o_idx = i_ptr + 2'(k);
    end
endmodule

// File: rtl/bus_arbiter4.sv
// bus_arbiter4: round-robin arbiter with bounded tenure for the shared 16-bit word path
module bus_arbiter4
    import bus_pkg::*;
#(
    parameter int MAX_HOLD = 8
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [0:NUM_REQ-1] i_req,
    output logic [0:NUM_REQ-1] o_gnt,
    output logic [0:1]         o_sel,
    output logic               o_busy
);
    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD);
    state_t        state;
    logic [0:1]    ptr;
    logic [0:1]    owner;
    logic [HW-1:0] hold;
    logic          pick_valid;
    logic [0:1]    pick_idx;
    rr_pick u_pick (
        .i_req  (i_req),
        .i_ptr  (ptr),
        .o_valid(pick_valid),
        .o_idx  (pick_idx)
    );
    // Every release passes through IDLE, which gives the bus its turnaround cycle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            ptr <= '0;
            owner <= '0;
            hold <= '0;
            o_gnt <= '0;
            o_sel <= '0;
        end else if (state == ST_IDLE) begin
            if (pick_valid) begin
                state <= ST_GRANT;
                owner <= pick_idx;
                o_sel <= pick_idx;
                o_gnt <= onehot4(pick_idx);
                hold <= HW'(1);
            end
        end else if (!i_req[owner] || hold == HOLD_MAX) begin
            state <= ST_IDLE;
            o_gnt <= '0;
            hold <= '0;
            ptr <= owner + 2'd1;
        end else begin
            hold <= hold + HW'(1);
        end
    end
    assign o_busy = (state == ST_GRANT);
endmodule

// File: tb/tb_bus_arbiter4.sv
// tb_bus_arbiter4: two arbiters (MAX_HOLD 8 and 2) against a behavioural round-robin model
module tb_bus_arbiter4;
    logic       clk = 1'b0;
    logic       rst;
    logic [0:3] req [2];
    logic [0:3] gnt_a, gnt_b;
    logic [0:1] sel_a, sel_b;
    logic       busy_a, busy_b;
    logic [0:3] gnt_v [2];
    logic [0:1] sel_v [2];
    logic       busy_v [2];
    int vectors = 0;
    int miscompares = 0;
    int m_ten [2];
    int m_owner [2];
    int m_ptr [2];
    int m_sel [2];
    bit m_valid = 1'b0;

    always #5 clk = ~clk;

    bus_arbiter4 #(.MAX_HOLD(8)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_req(req[0]),
        .o_gnt(gnt_a), .o_sel(sel_a), .o_busy(busy_a)
    );
    bus_arbiter4 #(.MAX_HOLD(2)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_req(req[1]),
        .o_gnt(gnt_b), .o_sel(sel_b), .o_busy(busy_b)
    );
    assign gnt_v[0] = gnt_a;
    assign gnt_v[1] = gnt_b;
    assign sel_v[0] = sel_a;
    assign sel_v[1] = sel_b;
    assign busy_v[0] = busy_a;
    assign busy_v[1] = busy_b;

    function automatic int maxh(input int i);
        return i == 0 ? 8 : 2;
    endfunction

    function automatic int pick(input logic [0:3] r, input int p);
        for (int k = 0; k < 4; k++)
            if (r[(p + k) % 4]) return (p + k) % 4;
        return -1;
    endfunction

    function automatic logic [6:0] act(input int i);
        return {gnt_v[i], sel_v[i], busy_v[i]};
    endfunction

    task automatic check(input string name, input logic [6:0] a, input logic [6:0] e);
        vectors++;
        if (a !== e) begin
            miscompares++;
            $display("FAIL %s t=%0t: got gnt=%b sel=%b busy=%b, expected gnt=%b sel=%b busy=%b",
                     name, $time, a[6:3], a[2:1], a[0], e[6:3], e[2:1], e[0]);
        end
    endtask

    task automatic lit(input int i, input string name, input logic [0:3] g,
                       input logic [0:1] s, input logic b);
        check(name, act(i), {g, s, b});
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    // Reference: a tenure is counted in granted cycles; 0 means the bus is idle.
    always @(posedge clk) begin
        if (rst) m_valid <= 1'b1;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                m_ten[i] <= 0;
                m_ptr[i] <= 0;
                m_owner[i] <= 0;
                m_sel[i] <= 0;
            end else if (m_ten[i] == 0) begin
                if (pick(req[i], m_ptr[i]) >= 0) begin
                    m_owner[i] <= pick(req[i], m_ptr[i]);
                    m_sel[i] <= pick(req[i], m_ptr[i]);
                    m_ten[i] <= 1;
                end
            end else if (!req[i][m_owner[i]] || m_ten[i] == maxh(i)) begin
                m_ten[i] <= 0;
                m_ptr[i] <= (m_owner[i] + 1) % 4;
            end else begin
                m_ten[i] <= m_ten[i] + 1;
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid)
            for (int i = 0; i < 2; i++)
                check(i == 0 ? "model_a" : "model_b", act(i),
                      {m_ten[i] > 0 ? 4'b1000 >> m_owner[i] : 4'b0000, 2'(m_sel[i]), m_ten[i] > 0});
    end

    initial begin
        rst = 1'b1;
        req[0] = 4'b0000;
        req[1] = 4'b0000;
        step;
        step;
        rst = 1'b0;
        lit(0, "reset_a", 4'b0000, 2'b00, 1'b0);
        lit(1, "reset_b", 4'b0000, 2'b00, 1'b0);
        req[0] = 4'b0100;
        repeat (3) begin
            step;
            lit(0, "short_gnt", 4'b0100, 2'b01, 1'b1);
        end
        req[0] = 4'b0000;
        step;
        lit(0, "short_rel", 4'b0000, 2'b01, 1'b0);
        req[0] = 4'b0010;
        step;
        lit(0, "pre_rst_gnt", 4'b0010, 2'b10, 1'b1);
        rst = 1'b1;
        req[0] = 4'b0000;
        step;
        rst = 1'b0;
        lit(0, "mid_rst", 4'b0000, 2'b00, 1'b0);
        step;
        lit(0, "post_rst_idle", 4'b0000, 2'b00, 1'b0);
        req[0] = 4'b0010;
        step;
        lit(0, "post_rst_gnt", 4'b0010, 2'b10, 1'b1);
        req[0] = 4'b0000;
        step;
        lit(0, "post_rst_rel", 4'b0000, 2'b10, 1'b0);
        req[0] = 4'b0001;
        for (int c = 1; c <= 20; c++) begin
            step;
            lit(0, "forced", c % 9 == 0 ? 4'b0000 : 4'b0001, 2'b11, c % 9 != 0);
        end
        req[0] = 4'b0000;
        step;
        lit(0, "forced_end", 4'b0000, 2'b11, 1'b0);
        req[0] = 4'b0001;
        step;
        lit(0, "wrap_gnt3", 4'b0001, 2'b11, 1'b1);
        req[0] = 4'b1001;
        repeat (7) step;
        lit(0, "wrap_hold", 4'b0001, 2'b11, 1'b1);
        step;
        lit(0, "wrap_rel", 4'b0000, 2'b11, 1'b0);
        step;
        lit(0, "wrap_gnt0", 4'b1000, 2'b00, 1'b1);
        req[0] = 4'b0001;
        step;
        lit(0, "wrap_rel0", 4'b0000, 2'b00, 1'b0);
        step;
        lit(0, "wrap_gnt3b", 4'b0001, 2'b11, 1'b1);
        req[0] = 4'b0000;
        step;
        lit(0, "wrap_idle", 4'b0000, 2'b11, 1'b0);
        req[0] = 4'b0100;
        step;
        lit(0, "nonown_gnt1", 4'b0100, 2'b01, 1'b1);
        req[0] = 4'b0110;
        step;
        lit(0, "nonown_pulse", 4'b0100, 2'b01, 1'b1);
        req[0] = 4'b0100;
        step;
        lit(0, "nonown_after", 4'b0100, 2'b01, 1'b1);
        req[0] = 4'b0010;
        step;
        lit(0, "nonown_rel", 4'b0000, 2'b01, 1'b0);
        step;
        lit(0, "nonown_gnt2", 4'b0010, 2'b10, 1'b1);
        req[0] = 4'b0000;
        step;
        lit(0, "nonown_idle", 4'b0000, 2'b10, 1'b0);
        rst = 1'b1;
        step;
        rst = 1'b0;
        req[1] = 4'b1111;
        for (int c = 1; c <= 14; c++) begin
            step;
            lit(1, "rotate", c % 3 == 0 ? 4'b0000 : 4'b1000 >> (((c - 1) / 3) % 4),
                2'(((c - 1) / 3) % 4), c % 3 != 0);
        end
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 2; i++)
                if ($urandom_range(3) == 0) req[i] = 4'($urandom);
            rst = ($urandom_range(99) == 0);
            step;
        end
        rst = 1'b0;
        req[0] = 4'b0000;
        req[1] = 4'b0000;
        step;
        step;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
